// File: rtl/or_event_pkg.sv
// Shared types and helpers for the OR-event capture block: FSM state encoding,
// ID width derivation and the lowest-set-index priority function.
package or_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // An ID must be at least one bit wide even for the smallest N.
  function automatic int unsigned calc_iw(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

  function automatic int unsigned lowest_set(input logic [31:0] vec);
    int unsigned idx;
    idx = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) begin
        idx = i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/or_event_capture_if.sv
// Request/mask/ack/IRQ bundle between the OR fabric side and the IRQ consumer.
interface or_event_capture_if import or_event_pkg::*; #(
  parameter int unsigned N = 4
) ();
  localparam int unsigned IW = calc_iw(N);

  logic [N-1:0]  req;
  logic [N-1:0]  mask;
  logic          ack_valid;
  logic [IW-1:0] ack_id;
  logic          ack_ready;
  logic          irq;
  logic [IW-1:0] irq_id;
  logic [N-1:0]  pend;

  modport master (
    output req, mask, ack_valid, ack_id,
    input  ack_ready, irq, irq_id, pend
  );

  modport slave (
    input  req, mask, ack_valid, ack_id,
    output ack_ready, irq, irq_id, pend
  );
endinterface

// File: rtl/or_event_sync_edge.sv
// One request bit: multi-flop synchroniser, history flop and rising-edge detect.
// A warm-up chain stops a level already high at reset release from reading as an edge.
module or_event_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rn_i,
  input  logic req_i,
  output logic edge_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   vld_q;

  // Synchroniser, edge history and warm-up tracking.
  always_ff @(posedge clk_i) begin
    if (!rn_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // prev_q only holds a genuinely sampled level once the warm-up chain is full.
  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q & vld_q[SYNC_STAGES];
endmodule

// File: rtl/or_event_capture.sv
// Captures rising edges of OR-merged request nets into sticky pending bits and
// serves them one at a time as a masked, lowest-index-first interrupt with ID ack.
module or_event_capture import or_event_pkg::*; #(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rn_i,
  or_event_capture_if.slave   evt_if
);
  localparam int unsigned IW = calc_iw(N);

  logic [N-1:0]  rise_s;
  logic [N-1:0]  clr_s;
  logic [N-1:0]  masked_s;
  logic          ack_hit_s;
  logic [N-1:0]  pend_d;
  logic          cand_vld_d;
  logic [IW-1:0] cand_id_d;

  logic [N-1:0]  pend_q;
  logic          cand_vld_q;
  logic [IW-1:0] cand_id_q;
  state_e        state_q;
  logic          irq_q;
  logic          ack_ready_q;
  logic [IW-1:0] irq_id_q;

  for (genvar g = 0; g < N; g++) begin : g_sync
    or_event_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk_i  (clk_i),
      .rn_i   (rn_i),
      .req_i  (evt_if.req[g]),
      .edge_o (rise_s[g])
    );
  end

  assign ack_hit_s  = (state_q == ST_ASSERT) && evt_if.ack_valid && (evt_if.ack_id == irq_id_q);
  assign masked_s   = pend_q & evt_if.mask;
  assign cand_vld_d = |masked_s;
  assign cand_id_d  = IW'(lowest_set(32'(masked_s)));

  // One-hot clear of the bit being acknowledged.
  always_comb begin
    clr_s = '0;
    if (ack_hit_s) begin
      clr_s[irq_id_q] = 1'b1;
    end else begin
      clr_s = '0;
    end
  end

  // Set is ORed in after the clear so a fresh edge survives a same-cycle ack.
  assign pend_d = (pend_q & ~clr_s) | rise_s;

  // Pending bits, registered priority candidate and the service FSM.
  always_ff @(posedge clk_i) begin
    if (!rn_i) begin
      pend_q      <= '0;
      cand_vld_q  <= 1'b0;
      cand_id_q   <= '0;
      state_q     <= ST_IDLE;
      irq_q       <= 1'b0;
      ack_ready_q <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      pend_q     <= pend_d;
      cand_vld_q <= cand_vld_d;
      cand_id_q  <= cand_id_d;
      case (state_q)
        ST_IDLE: begin
          // Re-check the candidate against live state in case its mask dropped.
          if (cand_vld_q && pend_q[cand_id_q] && evt_if.mask[cand_id_q]) begin
            state_q     <= ST_ASSERT;
            irq_q       <= 1'b1;
            ack_ready_q <= 1'b1;
            irq_id_q    <= cand_id_q;
          end else begin
            irq_q       <= 1'b0;
            ack_ready_q <= 1'b0;
          end
        end
        ST_ASSERT: begin
          if (ack_hit_s) begin
            state_q     <= ST_GAP;
            irq_q       <= 1'b0;
            ack_ready_q <= 1'b0;
          end else if (!evt_if.mask[irq_id_q]) begin
            state_q     <= ST_IDLE;
            irq_q       <= 1'b0;
            ack_ready_q <= 1'b0;
          end else begin
            irq_q       <= 1'b1;
            ack_ready_q <= 1'b1;
          end
        end
        ST_GAP: begin
          state_q     <= ST_IDLE;
          irq_q       <= 1'b0;
          ack_ready_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          irq_q       <= 1'b0;
          ack_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign evt_if.pend      = pend_q;
  assign evt_if.irq       = irq_q;
  assign evt_if.irq_id    = irq_id_q;
  assign evt_if.ack_ready = ack_ready_q;
endmodule
